// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational 64-bit ALU between two requesters.
// Round-robin grant in IDLE, registered operands in EXEC, held response in RESP.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for a request; req_ready asserted to the granted one
//   EXEC  | captured operands drive the ALU; result registered at end
//   RESP  | resp_valid[owner] high; wait for resp_ready[owner]
module alu_share_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input  logic [63:0]     req_a0,
  input  logic [63:0]     req_a1,
  input  logic [63:0]     req_b0,
  input  logic [63:0]     req_b1,
  input  logic [3:0]      req_op0,
  input  logic [3:0]      req_op1,
  output logic [NREQ-1:0] resp_valid,
  input  logic [NREQ-1:0] resp_ready,
  output logic [63:0]     resp_result,
  output logic            resp_zero,
  output logic            resp_err,
  output logic [63:0]     alu_a,
  output logic [63:0]     alu_b,
  output logic [3:0]      alu_op,
  input  logic [63:0]     alu_result,
  input  logic            alu_zero,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;

  state_t state_q, state_d;
  logic   prio_q;
  logic   owner_q;
  logic   grant;
  logic   accept;
  logic   done;
  logic   op_legal;

  // Opcode legality of the captured operation; illegal ones never reach resp_result.
  always_comb begin
    op_legal = 1'b0;
    case (alu_op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR, OP_SLL: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  end

  // Next-state, grant selection and handshake outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = '0;
    resp_valid = '0;
    grant      = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        // A lone requester wins outright; prio only breaks ties.
        if (req_valid == 2'b01)      grant = 1'b0;
        else if (req_valid == 2'b10) grant = 1'b1;
        else                         grant = prio_q;
        if (|req_valid) begin
          accept    = 1'b1;
          req_ready = grant ? 2'b10 : 2'b01;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        resp_valid = owner_q ? 2'b10 : 2'b01;
        // Only the owner's resp_ready can close the transaction.
        if (resp_ready[owner_q]) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Round-robin priority: flips away from the owner only when its response completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  prio_q <= 1'b0;
    else if (done) prio_q <= ~owner_q;
  end

  // Operand capture on acceptance; these registers drive the ALU directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q <= 1'b0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= OP_ADD;
    end else if (accept) begin
      owner_q <= grant;
      alu_a   <= grant ? req_a1  : req_a0;
      alu_b   <= grant ? req_b1  : req_b0;
      alu_op  <= grant ? req_op1 : req_op0;
    end
  end

  // Result capture at the end of EXEC; held unchanged through RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_result <= '0;
      resp_zero   <= 1'b0;
      resp_err    <= 1'b0;
    end else if (state_q == EXEC) begin
      if (op_legal) begin
        resp_result <= alu_result;
        resp_zero   <= alu_zero;
        resp_err    <= 1'b0;
      end else begin
        resp_result <= '0;
        resp_zero   <= 1'b1;
        resp_err    <= 1'b1;
      end
    end
  end

  assign busy = (state_q != IDLE);

endmodule
